// File: rtl/add_share_arb_pkg.sv
// Shared constants, FSM state type and a small modulo helper for add_share_arb.
package add_share_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // (base + off) mod n, for base/off already below n
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W-1:0] off,
                                               input int              n);
    logic [ID_W:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= (ID_W+1)'(n)) s = s - (ID_W+1)'(n);
    return s[ID_W-1:0];
  endfunction

endpackage

// File: rtl/RCA_16bit.sv
// 16-bit ripple-carry adder: the single shared datapath instance.
module RCA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  // Full-adder chain, carry ripples from bit 0 upward
  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = c[16];

endmodule

// File: rtl/add_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import add_share_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic            o_valid,
  output logic [ID_W-1:0] o_idx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate so bit 0 is the requester at ptr
  assign w_dbl   = {i_req, i_req} >> i_ptr;
  assign w_rot   = w_dbl[N-1:0];
  assign o_valid = |i_req;

  // Lowest rotated position wins; scan high-to-low so it is written last
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) o_idx = wrap_add(i_ptr, ID_W'(k), N);
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin sharing of one RCA_16bit among NUM_REQ requesters.
// IDLE latches the winner's operands, EXEC lets the adder settle a full
// cycle, RESP presents the registered result with a one-cycle ack.
// Optional: define ADD_SHARE_ARB_OVF_EN to add the rsp_ovf output.
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [DATA_W*NUM_REQ-1:0]   op_a,
  input  logic [DATA_W*NUM_REQ-1:0]   op_b,
  input  logic [NUM_REQ-1:0]          cin,
  input  logic [NUM_REQ-1:0]          sub,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        rsp_valid,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_W-1:0]           rsp_sum,
  output logic                        rsp_cout,
`ifdef ADD_SHARE_ARB_OVF_EN
  output logic                        rsp_ovf,
`endif
  output logic                        busy
);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_cin;
  logic [ID_W-1:0]     r_id;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_sum;
  logic                r_cout;

  logic                w_win_vld;
  logic [ID_W-1:0]     w_win;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic                w_cin;
  logic [DATA_W-1:0]   w_sum;
  logic                w_cout;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_win_vld),
    .o_idx   (w_win)
  );

  // Winner operand mux; subtract becomes A + ~B + 1
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_a   = op_a[i*DATA_W +: DATA_W];
        w_b   = sub[i] ? ~op_b[i*DATA_W +: DATA_W] : op_b[i*DATA_W +: DATA_W];
        w_cin = sub[i] | cin[i];
      end
    end
  end

  RCA_16bit u_rca (
    .a    (r_a),
    .b    (r_b),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Arbitration FSM, operand capture and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
      r_id     <= '0;
      r_rsp_id <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_win_vld) begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_cin   <= w_cin;
          r_id    <= w_win;
          r_state <= EXEC;
        end
        EXEC: begin
          r_sum    <= w_sum;
          r_cout   <= w_cout;
          r_rsp_id <= r_id;
          r_state  <= RESP;
        end
        RESP: begin
          r_ptr   <= wrap_add(r_rsp_id, ID_W'(1), NUM_REQ);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ADD_SHARE_ARB_OVF_EN
  logic r_ovf;

  // Signed overflow: like-signed operands giving an opposite-signed sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (r_state == EXEC)  r_ovf <= (r_a[15] == r_b[15]) && (w_sum[15] != r_a[15]);
  end

  assign rsp_ovf = r_ovf;
`endif

  // Ack decoded purely from registered state
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++)
      ack[i] = (r_state == RESP) && (r_rsp_id == ID_W'(i));
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a transaction-level model predicts
// each grant and its result; a monitor compares whenever rsp_valid is high.
module tb_add_share_arb;

  localparam int N = 4;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [16*N-1:0]   op_a, op_b;
  logic [N-1:0]      cin, sub;
  logic [N-1:0]      ack;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [15:0]       rsp_sum;
  logic              rsp_cout;
  logic              busy;
`ifdef ADD_SHARE_ARB_OVF_EN
  logic              rsp_ovf;
`endif

  add_share_arb #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADD_SHARE_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   m_ptr  = 0;
  int   m_hold = 0;

  // After a grant the arbiter is deaf for two further edges
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ptr  = 0;
      m_hold = 0;
    end else begin
      cyc++;
      if (m_hold > 0) m_hold--;
      else if (req != 0) begin
        int          w;
        logic [15:0] a, bp;
        logic        ci;
        logic [16:0] t;
        exp_t        e;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        a  = op_a[w*16 +: 16];
        bp = sub[w] ? ~op_b[w*16 +: 16] : op_b[w*16 +: 16];
        ci = sub[w] ? 1'b1 : cin[w];
        t  = {1'b0, a} + {1'b0, bp} + {16'd0, ci};
        e.id   = w;
        e.sum  = t[15:0];
        e.cout = t[16];
        e.ovf  = (a[15] == bp[15]) && (t[15] != a[15]);
        e.cyc  = cyc;
        q.push_back(e);
        m_ptr  = (w + 1) % N;
        m_hold = 2;
      end
    end
  end

  // ---------------- monitor ----------------
  int          ord_id[$];
  int          ord_cyc[$];
  int          last_id;
  logic [15:0] last_sum;
  logic        last_cout;
  logic        last_ovf;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: got id %0d with no grant pending", rsp_id);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id",   32'(rsp_id),   32'(e.id));
        check("rsp_sum",  32'(rsp_sum),  32'(e.sum));
        check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        check("ack",      32'(ack),      32'(1 << e.id));
        check("latency",  32'(cyc),      32'(e.cyc + 1));
`ifdef ADD_SHARE_ARB_OVF_EN
        check("rsp_ovf",  32'(rsp_ovf),  32'(e.ovf));
`endif
      end
      ord_id.push_back(int'(rsp_id));
      ord_cyc.push_back(cyc);
      last_id   = int'(rsp_id);
      last_sum  = rsp_sum;
      last_cout = rsp_cout;
`ifdef ADD_SHARE_ARB_OVF_EN
      last_ovf  = rsp_ovf;
`else
      last_ovf  = 1'b0;
`endif
    end
  end

  // ---------------- driver ----------------
  bit hold_mode = 0;

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
    op_a[i*16 +: 16] = a;
    op_b[i*16 +: 16] = b;
    cin[i] = c;
    sub[i] = s;
  endtask

  task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    set_ops(i, a, b, c, s);
    req[i] = 1'b1;
  endtask

  // Advance to next negedge; requesters react to their own ack
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        if (hold_mode) set_ops(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        else           req[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((req != 0 || busy) && t < 80) begin
      tick();
      t++;
    end
    if (t >= 80) begin
      n_chk++;
      $display("FAIL drain_timeout: req %b busy %b after %0d cycles", req, busy, t);
    end
    tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"},   32'(ack),       32'd0);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_id"},    32'(rsp_id),    32'd0);
    check({tag, "_sum"},   32'(rsp_sum),   32'd0);
    check({tag, "_cout"},  32'(rsp_cout),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
`ifdef ADD_SHARE_ARB_OVF_EN
    check({tag, "_ovf"},   32'(rsp_ovf),   32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; op_a = '0; op_b = '0; cin = '0; sub = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Wrap-around add on requester 0
    raise(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    check("t1_id", 32'(last_id), 32'd0);
    check("t1_sum", 32'(last_sum), 32'h0000);
    check("t1_cout", 32'(last_cout), 32'd1);

    // Subtract with borrow on requester 2
    raise(2, 16'd5, 16'd6, 1'b0, 1'b1);
    drain();
    check("t2_id", 32'(last_id), 32'd2);
    check("t2_sum", 32'(last_sum), 32'hFFFF);
    check("t2_cout", 32'(last_cout), 32'd0);

    // Fairness: after 3 is served, 1 and 3 together go 1 then 3
    raise(3, 16'h1234, 16'h1111, 1'b1, 1'b0);
    drain();
    ord_id.delete(); ord_cyc.delete();
    raise(1, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    raise(3, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1);
    drain();
    check("fair_count", 32'(ord_id.size()), 32'd2);
    if (ord_id.size() >= 2) begin
      check("fair_first", 32'(ord_id[0]), 32'd1);
      check("fair_second", 32'(ord_id[1]), 32'd3);
    end

    // Round-robin with all requesters held high
    ord_id.delete(); ord_cyc.delete();
    hold_mode = 1;
    for (int i = 0; i < N; i++)
      raise(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    begin
      int t;
      t = 0;
      while (ord_id.size() < 5 && t < 60) begin tick(); t++; end
    end
    hold_mode = 0;
    drain();
    check("rr_count", 32'(ord_id.size() >= 5), 32'd1);
    if (ord_id.size() >= 5) begin
      check("rr_0", 32'(ord_id[0]), 32'd0);
      check("rr_1", 32'(ord_id[1]), 32'd1);
      check("rr_2", 32'(ord_id[2]), 32'd2);
      check("rr_3", 32'(ord_id[3]), 32'd3);
      check("rr_4", 32'(ord_id[4]), 32'd0);
      for (int k = 0; k < 4; k++)
        check("rr_spacing", 32'(ord_cyc[k+1] - ord_cyc[k]), 32'd3);
    end

    // Mid-operation reset: move ptr to 2, then abort requester 3 in EXEC
    raise(1, 16'd7, 16'd8, 1'b0, 1'b0);
    drain();
    ord_id.delete(); ord_cyc.delete();
    raise(3, 16'h4000, 16'h4000, 1'b0, 1'b0);
    tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    tick();
    tick();
    check("midrst_no_ack", 32'(ord_id.size()), 32'd0);
    rst_n = 1'b1;
    raise(0, 16'h0102, 16'h0304, 1'b1, 1'b0);
    drain();
    check("midrst_count", 32'(ord_id.size()), 32'd2);
    if (ord_id.size() >= 2) begin
      check("midrst_first", 32'(ord_id[0]), 32'd0);
      check("midrst_second", 32'(ord_id[1]), 32'd3);
    end

`ifdef ADD_SHARE_ARB_OVF_EN
    raise(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();
    check("ovf_pos", 32'(last_ovf), 32'd1);
    raise(0, 16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();
    check("ovf_neg", 32'(last_ovf), 32'd1);
    raise(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
    drain();
    check("ovf_none", 32'(last_ovf), 32'd0);
`endif

    // Random traffic: idle requesters raise at random times
    for (int n = 0; n < 400; n++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(3) == 0)
          raise(i, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
